// File: rtl/ahb_slave_resp_mux_pkg.sv
// Shared AHB encodings and the data-phase state type for the slave response mux.
// Any block that decodes htrans/hresp or shares the data-phase states imports this package.
package AHB_package;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      D_IDLE,
      D_SLV,
      D_ERR1,
      D_ERR2
   } dstate_t;

   // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
   function automatic logic is_active(input logic [1:0] trans);
      return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_slave_resp_mux_onehot_chk.sv
// Flags whether a select vector has exactly one bit set.
// A zero vector and a multi-hot vector both report is_onehot = 0.
module ahb_onehot_chk #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] vec,
   output logic             is_onehot
);

   logic any_seen;
   logic multi_seen;

   // A second set bit is detected when a bit is found after one was already seen.
   always_comb begin
      any_seen   = 1'b0;
      multi_seen = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         multi_seen = multi_seen | (any_seen & vec[i]);
         any_seen   = any_seen | vec[i];
      end
   end

   assign is_onehot = any_seen & ~multi_seen;

endmodule

// File: rtl/ahb_slave_resp_mux.sv
// AHB data-phase response multiplexer: routes the selected slave's HRDATA/HREADYOUT/HRESP
// back to the master and answers decode errors with its own two-cycle ERROR response.
module ahb_slave_resp_mux
   import AHB_package::*;
#(
   parameter int CHANNEL_NUM = 2,
   parameter int DATA_W      = 32
) (
   input  logic                                hclk,
   input  logic                                hreset,
   input  logic [CHANNEL_NUM-1:0]              hsel,
   input  logic [1:0]                          htrans,
   input  logic [CHANNEL_NUM-1:0][DATA_W-1:0]  hrdata_in,
   input  logic [CHANNEL_NUM-1:0]              hreadyout_in,
   input  logic [CHANNEL_NUM-1:0]              hresp_in,
   output logic [DATA_W-1:0]                   hrdata,
   output logic                                hready,
   output logic                                hresp,
   output logic                                sel_err
);

   dstate_t                state_reg;
   dstate_t                state_next;
   logic [CHANNEL_NUM-1:0] dsel_reg;
   logic [CHANNEL_NUM-1:0] dsel_next;
   logic                   sel_err_reg;
   logic                   sel_err_next;
   logic                   hsel_onehot;

   logic [DATA_W-1:0]      masked_rdata [CHANNEL_NUM];
   logic [CHANNEL_NUM-1:0] masked_ready;
   logic [CHANNEL_NUM-1:0] masked_resp;
   logic [DATA_W-1:0]      slv_rdata;
   logic                   slv_ready;
   logic                   slv_resp;

   ahb_onehot_chk #(
      .WIDTH (CHANNEL_NUM)
   ) u_onehot_chk (
      .vec       (hsel),
      .is_onehot (hsel_onehot)
   );

   // AND-OR selection: dsel is one-hot in D_SLV, so at most one channel survives the mask.
   genvar gi;
   generate
      for (gi = 0; gi < CHANNEL_NUM; gi++) begin : g_mask
         assign masked_rdata[gi] = hrdata_in[gi] & {DATA_W{dsel_reg[gi]}};
         assign masked_ready[gi] = hreadyout_in[gi] & dsel_reg[gi];
         assign masked_resp[gi]  = hresp_in[gi] & dsel_reg[gi];
      end
   endgenerate

   always_comb begin
      slv_rdata = '0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
         slv_rdata = slv_rdata | masked_rdata[i];
      end
   end

   assign slv_ready = |masked_ready;
   assign slv_resp  = |masked_resp;

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_reg   <= D_IDLE;
         dsel_reg    <= '0;
         sel_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         dsel_reg    <= dsel_next;
         sel_err_reg <= sel_err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      dsel_next    = dsel_reg;
      sel_err_next = sel_err_reg;
      hrdata       = '0;
      hready       = 1'b1;
      hresp        = HRESP_OKAY;

      case (state_reg)
         D_SLV: begin
            hrdata = slv_rdata;
            hready = slv_ready;
            hresp  = slv_resp;
         end
         D_ERR1: begin
            hready = 1'b0;
            hresp  = HRESP_ERROR;
         end
         D_ERR2: begin
            hresp  = HRESP_ERROR;
         end
         default: begin
         end
      endcase

      // The first ERROR cycle always stalls, so only the second cycle may accept a new address.
      if (state_reg == D_ERR1) begin
         state_next = D_ERR2;
      end else if (hready) begin
         if (!is_active(htrans)) begin
            state_next = D_IDLE;
            dsel_next  = '0;
         end else if (hsel_onehot) begin
            state_next = D_SLV;
            dsel_next  = hsel;
         end else begin
            state_next   = D_ERR1;
            dsel_next    = '0;
            sel_err_next = 1'b1;
         end
      end
   end

   assign sel_err = sel_err_reg;

endmodule
